// File: rtl/rx_link_fault_ctrl.sv
// rx_link_fault_ctrl
// Receive-side link fault controller for the 10G MAC (rx_clk domain, beside rx_mac).
// Watches XGMII receive columns for Local/Remote Fault ordered sets and tracks
// link fault state. From that state it gates the rx_mac receive enable at frame
// boundaries, asks the TX path for Remote Fault or Idle, and flags frames cut by
// a fault sequence.
//
// Ports
//   rx_clk            receive clock, one XGMII column per cycle
//   rx_rst            asynchronous active-high reset
//   in_xgmii_data     RXD, lane 0 in bits [7:0] (32-bit only)
//   in_xgmii_ctl      RXC, bit i flags lane i as control
//   out_link_fault    00 OK, 01 Local Fault, 10 Remote Fault
//   out_rx_enable     receive enable to rx_mac
//   out_tx_send_rf    TX path should send Remote Fault (we see Local Fault)
//   out_tx_send_idle  TX path should send Idle only (we see Remote Fault)
//   out_frame_abort   one-cycle pulse, frame in progress was cut by a fault column
//   out_fault_cnt     saturating count of OK -> fault transitions
//
// Link fault states
//   state   | meaning
//   LINK_OK | no fault declared; receive may be enabled at the next idle column
//   LINK_LF | Local Fault declared; receive disabled, TX sends Remote Fault
//   LINK_RF | Remote Fault declared; receive disabled, TX sends Idle
module rx_link_fault_ctrl #(
   parameter int XGMII_DATA_WIDTH = 32,
   parameter int XGMII_DATA_BYTES = 4,
   parameter int FAULT_SEQ_THRESH = 4,
   parameter int COL_WINDOW       = 128,
   parameter int CNT_WIDTH        = 16
) (
   input  logic                        rx_clk,
   input  logic                        rx_rst,
   input  logic [XGMII_DATA_WIDTH-1:0] in_xgmii_data,
   input  logic [XGMII_DATA_BYTES-1:0] in_xgmii_ctl,
   output logic [1:0]                  out_link_fault,
   output logic                        out_rx_enable,
   output logic                        out_tx_send_rf,
   output logic                        out_tx_send_idle,
   output logic                        out_frame_abort,
   output logic [CNT_WIDTH-1:0]        out_fault_cnt
);

   typedef enum logic [1:0] {
      LINK_OK = 2'b00,
      LINK_LF = 2'b01,
      LINK_RF = 2'b10
   } link_e;

   localparam int SEQ_W = $clog2(FAULT_SEQ_THRESH + 1);
   localparam int COL_W = $clog2(COL_WINDOW + 1);
   localparam logic [SEQ_W-1:0] SEQ_MAX = SEQ_W'(FAULT_SEQ_THRESH);
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(COL_WINDOW);

   // column decode
   logic  col_fault;
   logic  col_start;
   logic  col_term;
   logic  col_idle;
   link_e col_type;

   // registered state
   link_e                link_q,      link_d;
   link_e                last_type_q, last_type_d;
   logic [SEQ_W-1:0]     seq_cnt_q,   seq_cnt_d;
   logic [COL_W-1:0]     col_cnt_q,   col_cnt_d;
   logic                 in_frame_q,  in_frame_d;
   logic                 abort_q,     abort_d;
   logic                 rx_en_q,     rx_en_d;
   logic [CNT_WIDTH-1:0] fault_cnt_q, fault_cnt_d;

   // Only sequence types 0x01 (LF) and 0x02 (RF) count; other 0x9C ordered
   // sets fall through as ordinary non-fault columns.
   always_comb begin
      col_fault = (in_xgmii_ctl == XGMII_DATA_BYTES'(1))
               && (in_xgmii_data[7:0]   == 8'h9C)
               && (in_xgmii_data[15:8]  == 8'h00)
               && (in_xgmii_data[23:16] == 8'h00)
               && ((in_xgmii_data[31:24] == 8'h01) || (in_xgmii_data[31:24] == 8'h02));
      col_type  = (in_xgmii_data[31:24] == 8'h02) ? LINK_RF : LINK_LF;
      col_start = in_xgmii_ctl[0] && (in_xgmii_data[7:0] == 8'hFB);
      col_idle  = (in_xgmii_ctl == '1) && (in_xgmii_data[7:0] != 8'hFB);
      col_term  = 1'b0;
      for (int i = 0; i < XGMII_DATA_BYTES; i++) begin
         if (in_xgmii_ctl[i] && (in_xgmii_data[8*i +: 8] == 8'hFD)) begin
            col_term = 1'b1;
         end
      end
   end

   always_ff @(posedge rx_clk or posedge rx_rst) begin
      if (rx_rst) begin
         link_q      <= LINK_OK;
         last_type_q <= LINK_LF;
         seq_cnt_q   <= '0;
         col_cnt_q   <= '0;
         in_frame_q  <= 1'b0;
         abort_q     <= 1'b0;
         rx_en_q     <= 1'b0;
         fault_cnt_q <= '0;
      end else begin
         link_q      <= link_d;
         last_type_q <= last_type_d;
         seq_cnt_q   <= seq_cnt_d;
         col_cnt_q   <= col_cnt_d;
         in_frame_q  <= in_frame_d;
         abort_q     <= abort_d;
         rx_en_q     <= rx_en_d;
         fault_cnt_q <= fault_cnt_d;
      end
   end

   always_comb begin
      link_d      = link_q;
      last_type_d = last_type_q;
      seq_cnt_d   = seq_cnt_q;
      col_cnt_d   = col_cnt_q;
      in_frame_d  = in_frame_q;
      abort_d     = 1'b0;
      rx_en_d     = rx_en_q;
      fault_cnt_d = fault_cnt_q;

      if (col_fault) begin
         // A fault column always wins over the window clear, even on the
         // column where the window would otherwise expire.
         col_cnt_d  = '0;
         in_frame_d = 1'b0;
         abort_d    = in_frame_q;
         if ((col_type == last_type_q) && (seq_cnt_q != '0)) begin
            if (seq_cnt_q != SEQ_MAX) begin
               seq_cnt_d = seq_cnt_q + SEQ_W'(1);
            end
         end else begin
            seq_cnt_d   = SEQ_W'(1);
            last_type_d = col_type;
         end
         // A type change while faulted restarts the count; the old fault
         // holds until the new type reaches threshold.
         if (seq_cnt_d == SEQ_MAX) begin
            link_d = col_type;
         end
      end else begin
         if (col_cnt_q != COL_MAX) begin
            col_cnt_d = col_cnt_q + COL_W'(1);
         end
         if (col_cnt_d == COL_MAX) begin
            seq_cnt_d = '0;
            link_d    = LINK_OK;
         end
         if (col_term) begin
            in_frame_d = 1'b0;
         end else if (col_start) begin
            in_frame_d = 1'b1;
         end
      end

      // Receive enable drops with the fault and only returns on an idle
      // column, so rx_mac never sees the tail of a frame.
      if (link_q == LINK_OK) begin
         if (link_d != LINK_OK) begin
            rx_en_d = 1'b0;
            if (fault_cnt_q != '1) begin
               fault_cnt_d = fault_cnt_q + CNT_WIDTH'(1);
            end
         end else if (col_idle) begin
            rx_en_d = 1'b1;
         end
      end
   end

   assign out_link_fault   = link_q;
   assign out_rx_enable    = rx_en_q;
   assign out_tx_send_rf   = (link_q == LINK_LF);
   assign out_tx_send_idle = (link_q == LINK_RF);
   assign out_frame_abort  = abort_q;
   assign out_fault_cnt    = fault_cnt_q;

endmodule

// File: tb/tb_rx_link_fault_ctrl.sv
module tb_rx_link_fault_ctrl;
   localparam int THRESH = 4;
   localparam int WIN    = 128;
   localparam int CW     = 16;

   localparam logic [31:0] IDLE_D = 32'h07070707;
   localparam logic [31:0] LF_D   = 32'h0100009C;
   localparam logic [31:0] RF_D   = 32'h0200009C;
   localparam logic [31:0] SOF_D  = 32'h555555FB;

   logic          rx_clk = 1'b0;
   logic          rx_rst = 1'b1;
   logic [31:0]   d = 32'h07070707;
   logic [3:0]    c = 4'hF;
   logic [1:0]    out_link_fault;
   logic          out_rx_enable;
   logic          out_tx_send_rf;
   logic          out_tx_send_idle;
   logic          out_frame_abort;
   logic [CW-1:0] out_fault_cnt;

   int checks = 0;
   int errors = 0;

   // behavioural model: fault runs, gap since last fault, frame flag
   int m_link;
   int m_run_type;
   int m_run_len;
   int m_gap;
   int m_cnt;
   bit m_in_frame;
   bit m_abort;
   bit m_rx_en;

   rx_link_fault_ctrl #(
      .XGMII_DATA_WIDTH(32),
      .XGMII_DATA_BYTES(4),
      .FAULT_SEQ_THRESH(THRESH),
      .COL_WINDOW(WIN),
      .CNT_WIDTH(CW)
   ) dut (
      .rx_clk(rx_clk),
      .rx_rst(rx_rst),
      .in_xgmii_data(d),
      .in_xgmii_ctl(c),
      .out_link_fault(out_link_fault),
      .out_rx_enable(out_rx_enable),
      .out_tx_send_rf(out_tx_send_rf),
      .out_tx_send_idle(out_tx_send_idle),
      .out_frame_abort(out_frame_abort),
      .out_fault_cnt(out_fault_cnt)
   );

   always #5 rx_clk = ~rx_clk;

   function automatic logic [21:0] obs();
      return {out_link_fault, out_rx_enable, out_tx_send_rf, out_tx_send_idle,
              out_frame_abort, out_fault_cnt};
   endfunction

   function automatic logic [21:0] exp_v();
      return {2'(m_link), m_rx_en, (m_link == 1), (m_link == 2), m_abort, 16'(m_cnt)};
   endfunction

   task automatic model_reset();
      m_link = 0; m_run_type = 1; m_run_len = 0; m_gap = 0; m_cnt = 0;
      m_in_frame = 0; m_abort = 0; m_rx_en = 0;
   endtask

   task automatic model_col(input logic [31:0] dd, input logic [3:0] cc);
      bit f, st, tm, idl;
      int ftype, prev;
      f     = (cc == 4'b0001) && (dd[23:0] == 24'h00009C) &&
              ((dd[31:24] == 8'h01) || (dd[31:24] == 8'h02));
      ftype = (dd[31:24] == 8'h02) ? 2 : 1;
      st    = cc[0] && (dd[7:0] == 8'hFB);
      idl   = (cc == 4'hF) && (dd[7:0] != 8'hFB);
      tm    = 0;
      for (int i = 0; i < 4; i++) if (cc[i] && dd[8*i +: 8] == 8'hFD) tm = 1;
      prev    = m_link;
      m_abort = f && m_in_frame;
      if (f) begin
         m_gap = 0;
         if (ftype == m_run_type && m_run_len > 0) m_run_len++;
         else begin m_run_len = 1; m_run_type = ftype; end
         if (m_run_len >= THRESH) m_link = ftype;
         m_in_frame = 0;
      end else begin
         m_gap++;
         if (m_gap >= WIN) begin m_run_len = 0; m_link = 0; end
         if (tm) m_in_frame = 0;
         else if (st) m_in_frame = 1;
      end
      if (prev == 0 && m_link != 0) begin
         m_rx_en = 0;
         if (m_cnt < 65535) m_cnt++;
      end else if (prev == 0 && idl) begin
         m_rx_en = 1;
      end
   endtask

   task automatic col(input logic [31:0] dd, input logic [3:0] cc);
      d = dd; c = cc;
      @(posedge rx_clk);
      model_col(dd, cc);
      #1;
   endtask

   task automatic idles(input int n);
      for (int i = 0; i < n; i++) col(IDLE_D, 4'hF);
   endtask

   task automatic test_reset();
      rx_rst = 1'b1; d = IDLE_D; c = 4'hF; model_reset();
      #2;
      checks++;
      if (obs() !== 22'd0) begin errors++; $display("FAIL reset_outputs got %h want %h", obs(), 22'd0); end
      @(posedge rx_clk); #1; rx_rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         col(IDLE_D, 4'hF);
         checks++;
         if (obs() !== exp_v()) begin errors++; $display("FAIL idle_after_reset col %0d got %h want %h", i, obs(), exp_v()); end
      end
      checks++;
      if ({out_link_fault, out_rx_enable, out_fault_cnt} !== {2'b00, 1'b1, 16'd0}) begin
         errors++; $display("FAIL reset_then_idle got %b/%b/%0d want 00/1/0", out_link_fault, out_rx_enable, out_fault_cnt);
      end
   endtask

   task automatic test_lf_fault();
      for (int k = 0; k < 4; k++) begin
         idles(10);
         col(LF_D, 4'h1);
         checks++;
         if (obs() !== exp_v()) begin errors++; $display("FAIL lf_seq %0d got %h want %h", k, obs(), exp_v()); end
      end
      checks++;
      if ({out_link_fault, out_tx_send_rf, out_rx_enable, out_fault_cnt} !== {2'b01, 1'b1, 1'b0, 16'd1}) begin
         errors++; $display("FAIL lf_declared got %b/%b/%b/%0d want 01/1/0/1", out_link_fault, out_tx_send_rf, out_rx_enable, out_fault_cnt);
      end
      idles(128);
      checks++;
      if ({out_link_fault, out_tx_send_rf, out_rx_enable} !== {2'b00, 1'b0, 1'b0}) begin
         errors++; $display("FAIL lf_cleared got %b/%b/%b want 00/0/0", out_link_fault, out_tx_send_rf, out_rx_enable);
      end
      col(IDLE_D, 4'hF);
      checks++;
      if (out_rx_enable !== 1'b1) begin errors++; $display("FAIL rx_enable_rise got %b want 1", out_rx_enable); end
   endtask

   task automatic test_type_switch();
      for (int k = 0; k < 3; k++) begin idles(2); col(LF_D, 4'h1); end
      idles(2); col(RF_D, 4'h1);
      checks++;
      if (out_link_fault !== 2'b00 || out_rx_enable !== 1'b1) begin
         errors++; $display("FAIL lf_rf_mix got %b/%b want 00/1", out_link_fault, out_rx_enable);
      end
      for (int k = 0; k < 3; k++) begin idles(2); col(RF_D, 4'h1); end
      checks++;
      if ({out_link_fault, out_tx_send_idle, out_tx_send_rf, out_fault_cnt} !== {2'b10, 1'b1, 1'b0, 16'd2}) begin
         errors++; $display("FAIL rf_declared got %b/%b/%b/%0d want 10/1/0/2", out_link_fault, out_tx_send_idle, out_tx_send_rf, out_fault_cnt);
      end
      idles(129);
      checks++;
      if (obs() !== exp_v()) begin errors++; $display("FAIL rf_recover got %h want %h", obs(), exp_v()); end
   endtask

   task automatic test_window();
      col(LF_D, 4'h1);
      for (int k = 0; k < 3; k++) begin idles(128); col(LF_D, 4'h1); end
      checks++;
      if (out_link_fault !== 2'b00 || out_fault_cnt !== 16'd2) begin
         errors++; $display("FAIL window_128 got %b/%0d want 00/2", out_link_fault, out_fault_cnt);
      end
      idles(128);
      col(LF_D, 4'h1);
      for (int k = 0; k < 3; k++) begin
         idles(127); col(LF_D, 4'h1);
         checks++;
         if (obs() !== exp_v()) begin errors++; $display("FAIL window_127 step %0d got %h want %h", k, obs(), exp_v()); end
      end
      checks++;
      if (out_link_fault !== 2'b01 || out_fault_cnt !== 16'd3) begin
         errors++; $display("FAIL window_127_fault got %b/%0d want 01/3", out_link_fault, out_fault_cnt);
      end
      idles(129);
   endtask

   task automatic test_frame_abort();
      col(SOF_D, 4'h1);
      for (int i = 0; i < 3; i++) col($urandom, 4'h0);
      col(LF_D, 4'h1);
      checks++;
      if ({out_frame_abort, out_rx_enable, out_link_fault} !== {1'b1, 1'b1, 2'b00}) begin
         errors++; $display("FAIL abort_pulse got %b/%b/%b want 1/1/00", out_frame_abort, out_rx_enable, out_link_fault);
      end
      col(IDLE_D, 4'hF);
      checks++;
      if (out_frame_abort !== 1'b0) begin errors++; $display("FAIL abort_width got %b want 0", out_frame_abort); end
      for (int k = 0; k < 3; k++) begin col(LF_D, 4'h1); idles(1); end
      checks++;
      if ({out_link_fault, out_rx_enable, out_frame_abort, out_fault_cnt} !== {2'b01, 1'b0, 1'b0, 16'd4}) begin
         errors++; $display("FAIL abort_then_fault got %b/%b/%b/%0d want 01/0/0/4", out_link_fault, out_rx_enable, out_frame_abort, out_fault_cnt);
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 3; k++) begin idles(5); col(RF_D, 4'h1); end
      checks++;
      if (out_link_fault !== 2'b01) begin errors++; $display("FAIL lf_holds got %b want 01", out_link_fault); end
      idles(5); col(RF_D, 4'h1);
      checks++;
      if (out_link_fault !== 2'b10 || out_fault_cnt !== 16'd4) begin
         errors++; $display("FAIL lf_to_rf got %b/%0d want 10/4", out_link_fault, out_fault_cnt);
      end
      col(SOF_D, 4'h1);
      col($urandom, 4'h0);
      #3; rx_rst = 1'b1;
      #1;
      checks++;
      if (obs() !== 22'd0) begin errors++; $display("FAIL async_reset got %h want %h", obs(), 22'd0); end
      model_reset();
      @(posedge rx_clk); @(posedge rx_clk); #1; rx_rst = 1'b0;
      col(LF_D, 4'h1);
      checks++;
      if (out_frame_abort !== 1'b0 || obs() !== exp_v()) begin
         errors++; $display("FAIL frame_cleared_by_reset got %h want %h", obs(), exp_v());
      end
      idles(10);
      checks++;
      if ({out_link_fault, out_rx_enable, out_fault_cnt} !== {2'b00, 1'b1, 16'd0}) begin
         errors++; $display("FAIL post_reset_ok got %b/%b/%0d want 00/1/0", out_link_fault, out_rx_enable, out_fault_cnt);
      end
      idles(128);
   endtask

   task automatic test_random();
      for (int n = 0; n < 3000; n++) begin
         int kind, k, run;
         logic [31:0] dd;
         logic [3:0]  cc;
         kind = $urandom_range(0, 15);
         dd = IDLE_D; cc = 4'hF;
         case (kind)
            5, 6: begin dd = LF_D; cc = 4'h1; end
            7, 8: begin dd = RF_D; cc = 4'h1; end
            9:    begin dd = $urandom; dd[7:0] = 8'hFB; cc = 4'h1; end
            10:   begin dd = $urandom; cc = 4'h0; end
            11: begin
               k = $urandom_range(0, 3);
               dd = $urandom; cc = 4'h0;
               for (int i = 0; i < 4; i++) begin
                  if (i >= k) begin cc[i] = 1'b1; dd[8*i +: 8] = (i == k) ? 8'hFD : 8'h07; end
               end
            end
            12:   begin dd = {8'($urandom_range(3, 255)), 24'h00009C}; cc = 4'h1; end
            13:   begin dd = $urandom; cc = 4'($urandom); end
            default: ;
         endcase
         if (kind == 14 && $urandom_range(0, 3) == 0) begin
            run = $urandom_range(120, 135);
            for (int i = 0; i < run; i++) begin
               col(IDLE_D, 4'hF);
               checks++;
               if (obs() !== exp_v()) begin errors++; $display("FAIL random_gap n %0d i %0d got %h want %h", n, i, obs(), exp_v()); end
            end
         end else begin
            col(dd, cc);
            checks++;
            if (obs() !== exp_v()) begin errors++; $display("FAIL random n %0d col %h/%h got %h want %h", n, dd, cc, obs(), exp_v()); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_lf_fault();
      test_type_switch();
      test_window();
      test_frame_abort();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
